serial_to_parallel: RTL and testbench
=====================================

# serial_to_parallel

Receive-side counterpart of the 4-bit parallel_to_serial converter. It accepts a qualified serial bit stream one bit per clock and reassembles WIDTH-bit words. Each word is presented through a single-entry holding register with a valid/ready handshake. It sits at the far end of the serial link, and its s_data/s_valid inputs connect directly to the transmitter's s_data/valid outputs.

## Interface
- WIDTH, 4: bits per word; must be ≥ 2.
- MSB_FIRST, 1: 1 = first received bit lands in p_data[WIDTH-1]; 0 = first bit lands in p_data[0].
- CW, $clog2(WIDTH): width of the bit_count port. Derived; do not override.

Clocking: one clock; reset is synchronous and active-high.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- s_data  in  1  serial data bit.
- s_valid  in  1  s_data is a real bit this cycle.
- flush  in  1  discard the partially assembled word.
- p_data  out  WIDTH  assembled word in the holding register.
- p_valid  out  1  holding register contains an unconsumed word.
- p_ready  in  1  consumer accepts p_data this cycle.
- bit_count  out  CW  bits in the current partial word, 0..WIDTH-1.
- busy  out  1  bit_count != 0.
- overrun  out  1  sticky flag: a completed word was dropped.

## Operation
- Shifter state machine:
  - IDLE: bit_count = 0.
  - SHIFT: 1 ≤ bit_count ≤ WIDTH-1.
  - IDLE→SHIFT on an accepted bit.
  - SHIFT→IDLE on completion (WIDTH-th bit accepted) or on flush.
- A bit is accepted when s_valid=1 and flush=0.
  - MSB_FIRST=1: shift left, new bit in at LSB.
  - MSB_FIRST=0: shift right, new bit in at MSB.
- Completion is the edge accepting the WIDTH-th bit. Assembled word (including that bit) goes to the holding register if the register is free.
- Holding register is free if p_valid=0, or p_valid=1 and p_ready=1 in the same cycle.
- Register not free at completion:
  - Completed word is dropped; overrun sets.
  - p_data and p_valid are unchanged.
  - Shifter still returns to IDLE.
- Handshake: the consumer takes the word on an edge where p_valid=1 and p_ready=1.
  - p_valid clears on that edge unless a completion loads a new word on the same edge.
  - If a new word loads, p_valid stays 1 and p_data updates.
- p_data holds its last value when p_valid=0.
- flush=1:
  - Clears bit_count and the shift register.
  - Drops any s_valid bit in that cycle (flush wins).
  - Clears overrun.
  - Does not touch the holding register or p_valid.
- s_valid gaps of any length: the shifter holds its state.
- No backpressure on the serial side; the block never stalls a bit.

## Timing
- Reset (rst=1 on an edge): p_data=0, p_valid=0, bit_count=0, busy=0, overrun=0, shift register=0. rst dominates flush, s_valid and p_ready.
- Reset mid-word discards the partial word and any held word.
- Latency: p_valid and p_data are valid in the cycle after the edge accepting the WIDTH-th bit (1 clock from last bit).
- Throughput: one word per WIDTH accepted bits. Back-to-back words need no idle cycles.
- bit_count increments on each accepted bit and wraps WIDTH-1 → 0 on completion. It never shows WIDTH.
- overrun rises the cycle after the dropping edge. It stays high until rst or flush.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
Scenarios 1–6 use WIDTH=4, MSB_FIRST=1 unless stated.

1. Reset: hold rst 2 cycles with s_valid=1 toggling s_data → p_valid=0, p_data=0000, bit_count=0, busy=0, overrun=0.
2. Basic word: p_ready=1; bits 1,0,1,0 on 4 consecutive s_valid cycles.
   - bit_count reads 1,2,3,0.
   - p_data=1010 with p_valid=1 for exactly one cycle after the 4th bit.
3. Gapped input: bits 1,1,1,1 with s_valid low 1–3 cycles between bits.
   - bit_count holds during gaps.
   - p_data=1111 once, after the 4th bit only.
4. Overrun: p_ready=0; send 1010 then 0101.
   - p_data stays 1010, p_valid=1, overrun=1 after the 8th bit.
   - Raise p_ready for one cycle → p_valid=0; overrun stays 1 until flush.
5. Simultaneous drain/load: hold 1010 with p_ready=0; send 0101, raising p_ready only in the 4th-bit cycle.
   - p_valid stays 1 and p_data becomes 0101.
   - overrun stays 0.
6. Flush, reset and bit order:
   - Flush with s_valid=1 after 2 bits → bit_count=0, that bit dropped; then 0101 → p_data=0101.
   - rst after 3 bits → bit_count=0, no word emitted.
   - MSB_FIRST=0, bits 1,0,1,0 → p_data=0101.

Source files
------------

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: reassembles a qualified serial bit stream into WIDTH-bit words
// behind a single-entry valid/ready holding register with a sticky overrun flag.
module serial_to_parallel #(
    parameter int WIDTH = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_data,
    input  logic             s_valid,
    input  logic             flush,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic [CW-1:0]    bit_count,
    output logic             busy,
    output logic             overrun
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sr_q, shift_d, p_data_q;
    logic             p_valid_q, ovr_q, accept, done, free;
    always_comb begin
        accept  = s_valid && !flush;
        shift_d = MSB_FIRST ? {sr_q[WIDTH-2:0], s_data} : {s_data, sr_q[WIDTH-1:1]};
        done    = accept && (cnt_q == CW'(WIDTH - 1));
        free    = !p_valid_q || p_ready;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            p_data_q  <= '0;
            p_valid_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            if (flush) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                sr_q    <= '0;
                ovr_q   <= 1'b0;
            end else if (done) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                sr_q    <= '0;
                ovr_q   <= ovr_q | !free;
            end else if (accept) begin
                state_q <= SHIFT;
                cnt_q   <= cnt_q + 1'b1;
                sr_q    <= shift_d;
            end
            // a completion into a free register wins over the consumer draining it
            if (done && free) begin
                p_data_q  <= shift_d;
                p_valid_q <= 1'b1;
            end else if (p_ready) begin
                p_valid_q <= 1'b0;
            end
        end
    end
    assign p_data    = p_data_q;
    assign p_valid   = p_valid_q;
    assign bit_count = cnt_q;
    assign busy      = (state_q == SHIFT);
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_serial_to_parallel.sv
// tb_serial_to_parallel: directed scoreboard bench for both bit orders of serial_to_parallel.
module tb_serial_to_parallel;
    logic       clk = 1'b0;
    logic       rst, s_data, s_valid, flush, p_ready, p_ready_l;
    logic [3:0] p_data, p_data_l;
    logic       p_valid, p_valid_l, busy, busy_l, overrun, overrun_l;
    logic [1:0] bit_count, bit_count_l;
    logic [3:0] sb_q[$];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    serial_to_parallel #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .flush(flush),
        .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
        .bit_count(bit_count), .busy(busy), .overrun(overrun)
    );

    serial_to_parallel #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .flush(flush),
        .p_data(p_data_l), .p_valid(p_valid_l), .p_ready(p_ready_l),
        .bit_count(bit_count_l), .busy(busy_l), .overrun(overrun_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // each cycle: on the falling edge, a word about to be consumed is popped from the scoreboard
    task automatic tick();
        @(negedge clk);
        if (!rst && p_valid && p_ready) begin
            checks++;
            assert (sb_q.size() != 0 && p_data === sb_q[0]) else begin
                failures++;
                $error("FAIL sb_word observed=%0h expected=%0h pending=%0d",
                       p_data, (sb_q.size() != 0) ? sb_q[0] : 4'h0, sb_q.size());
            end
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic b);
        s_valid = 1'b1;
        s_data  = b;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_data = 1'b0; s_valid = 1'b1; flush = 1'b0; p_ready = 1'b0; p_ready_l = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_data = ~s_data;
            tick();
        end
        s_valid = 1'b0;
        chk("rst_p_valid", p_valid, 0);
        chk("rst_p_data", p_data, 4'b0000);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        idle(1);

        p_ready = 1'b1;
        send(1); chk("basic_cnt1", bit_count, 1); chk("basic_busy1", busy, 1);
        send(0); chk("basic_cnt2", bit_count, 2);
        send(1); chk("basic_cnt3", bit_count, 3);
        sb_q.push_back(4'b1010);
        send(0); chk("basic_cnt0", bit_count, 0); chk("basic_busy0", busy, 0);
        chk("basic_valid", p_valid, 1); chk("basic_data", p_data, 4'b1010);
        idle(1); chk("basic_one_cycle", p_valid, 0);

        send(1); idle(1); chk("gap_hold1", bit_count, 1);
        send(1); idle(2); chk("gap_hold2", bit_count, 2); chk("gap_no_word", p_valid, 0);
        send(1); idle(3); chk("gap_hold3", bit_count, 3);
        sb_q.push_back(4'b1111);
        send(1); chk("gap_valid", p_valid, 1); chk("gap_data", p_data, 4'b1111);
        idle(3); chk("gap_once", p_valid, 0);

        p_ready = 1'b0;
        sb_q.push_back(4'b1010);
        send(1); send(0); send(1); send(0);
        chk("ovr_pre", overrun, 0);
        send(0); send(1); send(0); send(1);
        chk("ovr_data", p_data, 4'b1010); chk("ovr_valid", p_valid, 1); chk("ovr_set", overrun, 1);
        p_ready = 1'b1; idle(1); p_ready = 1'b0;
        chk("ovr_drained", p_valid, 0); chk("ovr_sticky", overrun, 1);
        idle(2); chk("ovr_sticky2", overrun, 1);
        flush = 1'b1; idle(1); flush = 1'b0;
        chk("ovr_flush_clr", overrun, 0);

        sb_q.push_back(4'b1010);
        send(1); send(0); send(1); send(0);
        send(0); send(1); send(0);
        sb_q.push_back(4'b0101);
        p_ready = 1'b1; send(1); p_ready = 1'b0;
        chk("sim_valid", p_valid, 1); chk("sim_data", p_data, 4'b0101); chk("sim_no_ovr", overrun, 0);
        p_ready = 1'b1; idle(1);
        chk("sim_drained", p_valid, 0);

        send(1); send(0);
        flush = 1'b1; send(1); flush = 1'b0;
        chk("flush_cnt", bit_count, 0); chk("flush_busy", busy, 0);
        sb_q.push_back(4'b0101);
        send(0); send(1); send(0); send(1);
        chk("flush_data", p_data, 4'b0101); chk("flush_valid", p_valid, 1);
        idle(1);

        send(1); send(1); send(1);
        chk("rst_mid_cnt_pre", bit_count, 3);
        rst = 1'b1; idle(1); rst = 1'b0;
        chk("rst_mid_cnt", bit_count, 0); chk("rst_mid_valid", p_valid, 0);
        idle(3); chk("rst_mid_no_word", p_valid, 0);

        sb_q.push_back(4'b1010);
        send(1); send(0); send(1); send(0);
        chk("lsb_valid", p_valid_l, 1); chk("lsb_data", p_data_l, 4'b0101);
        chk("msb_data", p_data, 4'b1010);
        idle(2);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
